// File: rtl/auth_framer.sv
// auth_framer: latches {timestamp, payload}, folds a 40-bit keyed rotate/XOR tag over
// the 27 header bytes (one byte per cycle, MSB first) and presents a 256-bit frame.
// Ports: in_valid/in_ready accept side, frame_valid/frame_ready/frame output side,
// busy while tagging or holding a frame, frame_count counts handoffs (wraps).
// Latency: accept edge 0 -> frame_valid after edge 27. No overlap: in_ready is low
// from acceptance until the frame is handed off; the frame is held while frame_ready=0.
module auth_framer #(
    parameter logic [39:0] KEY   = 40'h0,
    parameter int          CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [183:0]     payload,
    input  logic [31:0]      timestamp,
    output logic             frame_valid,
    input  logic             frame_ready,
    output logic [255:0]     frame,
    output logic             busy,
    output logic [CNT_W-1:0] frame_count
);

    localparam logic [4:0] LAST_BYTE = 5'd26;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_TAG  = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [215:0]       r_hdr;          // {timestamp, payload} as accepted
    logic [215:0]       r_shift;        // header shifted so the current byte sits on top
    logic [39:0]        r_acc;          // tag accumulator
    logic [4:0]         r_cnt;          // index of the byte being folded in
    logic [255:0]       r_frame;
    logic [CNT_W-1:0]   r_frame_count;

    logic               w_accept;
    logic               w_handoff;
    logic               w_last;
    logic [7:0]         w_byte;
    logic [39:0]        w_acc_nxt;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        frame_valid = 1'b0;
        busy        = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = S_TAG;
                end
            end
            S_TAG: begin
                busy = 1'b1;
                if (w_last) begin
                    w_state_nxt = S_OUT;
                end
            end
            S_OUT: begin
                frame_valid = 1'b1;
                busy        = 1'b1;
                if (frame_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign w_accept  = (r_state == S_IDLE) && in_valid;
    assign w_handoff = (r_state == S_OUT) && frame_ready;
    assign w_last    = (r_cnt == LAST_BYTE);

    // Current byte b_cnt is always the top byte of the shifted header copy.
    assign w_byte    = r_shift[215:208];

    // Rotate left by one, then XOR the byte into the low 8 bits (no carries).
    assign w_acc_nxt = {r_acc[38:0], r_acc[39]} ^ {32'h0, w_byte};

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hdr   <= '0;
            r_shift <= '0;
            r_acc   <= KEY;
            r_cnt   <= '0;
            r_frame <= '0;
        end else if (w_accept) begin
            r_hdr   <= {timestamp, payload};
            r_shift <= {timestamp, payload};
            r_acc   <= KEY;
            r_cnt   <= '0;
        end else if (r_state == S_TAG) begin
            r_acc   <= w_acc_nxt;
            r_cnt   <= r_cnt + 5'd1;
            r_shift <= {r_shift[207:0], 8'h00};
            // The edge that folds in the last byte also publishes the frame,
            // using the accumulator value being written on this same edge.
            if (w_last) begin
                r_frame <= {r_hdr, w_acc_nxt};
            end
        end
    end

    // Handoff counter; wraps silently.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_frame_count <= '0;
        end else if (w_handoff) begin
            r_frame_count <= r_frame_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign frame       = r_frame;
    assign frame_count = r_frame_count;

    // ------------------------------------------------------------------
    // Protocol properties
    // ------------------------------------------------------------------
    // A stalled frame must not move.
    property p_frame_hold;
        @(posedge clk) disable iff (!reset_n)
            (frame_valid && !frame_ready) |=> (frame_valid && $stable(frame));
    endproperty
    a_frame_hold: assert property (p_frame_hold);

    // Never ready for new input while a frame is in flight.
    property p_no_overlap;
        @(posedge clk) disable iff (!reset_n)
            busy |-> !in_ready;
    endproperty
    a_no_overlap: assert property (p_no_overlap);

endmodule

// File: tb/tb_auth_framer.sv
`timescale 1ns/1ps
module tb_auth_framer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Primary DUT: KEY=0, 16-bit counter
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [183:0] payload;
    logic [31:0]  timestamp;
    logic         frame_valid;
    logic         frame_ready;
    logic [255:0] frame;
    logic         busy;
    logic [15:0]  frame_count;

    // Secondary DUT: KEY=1, 3-bit counter so wrap-around is reachable quickly
    logic         d1_in_valid;
    logic         d1_in_ready;
    logic [183:0] d1_payload;
    logic [31:0]  d1_timestamp;
    logic         d1_frame_valid;
    logic         d1_frame_ready;
    logic [255:0] d1_frame;
    logic         d1_busy;
    logic [2:0]   d1_frame_count;

    logic [255:0] q0[$];
    logic [255:0] q1[$];
    logic [15:0]  exp_cnt0;
    logic [2:0]   exp_cnt1;

    auth_framer #(.KEY(40'h0), .CNT_W(16)) u_dut0 (
        .clk         (clk),
        .reset_n     (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .payload     (payload),
        .timestamp   (timestamp),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .frame       (frame),
        .busy        (busy),
        .frame_count (frame_count)
    );

    auth_framer #(.KEY(40'h1), .CNT_W(3)) u_dut1 (
        .clk         (clk),
        .reset_n     (rst_n),
        .in_valid    (d1_in_valid),
        .in_ready    (d1_in_ready),
        .payload     (d1_payload),
        .timestamp   (d1_timestamp),
        .frame_valid (d1_frame_valid),
        .frame_ready (d1_frame_ready),
        .frame       (d1_frame),
        .busy        (d1_busy),
        .frame_count (d1_frame_count)
    );

    // ---------------- reference model ----------------
    function automatic logic [39:0] rotl(input logic [39:0] x, input int n);
        logic [79:0] d;
        d = {x, x} << n;
        return d[79:40];
    endfunction

    // Closed form: the key is rotated 27 times; byte b_i is rotated 26-i times.
    function automatic logic [39:0] ref_tag(input logic [39:0] key, input logic [215:0] hdr);
        logic [39:0]  t;
        logic [215:0] h;
        t = rotl(key, 27);
        h = hdr;
        for (int i = 0; i < 27; i++) begin
            t = t ^ rotl({32'h0, h[215:208]}, 26 - i);
            h = h << 8;
        end
        return t;
    endfunction

    function automatic logic [183:0] rnd184();
        logic [191:0] r;
        for (int i = 0; i < 6; i++) r[i*32 +: 32] = $urandom;
        return r[183:0];
    endfunction

    // ---------------- primary DUT frame driver ----------------
    // Must be entered at a negedge with the DUT idle. Returns at the negedge
    // after the handoff edge, so a following call accepts on the very next edge.
    task automatic do_frame(input logic [31:0] ts, input logic [183:0] pl, input int stall);
        logic [255:0] exp;
        int n;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL accept_ready: in_ready=%b want 1", in_ready);
        end
        timestamp = ts; payload = pl; in_valid = 1'b1;
        q0.push_back({ts, pl, ref_tag(40'h0, {ts, pl})});
        @(negedge clk);                               // accept edge 0 has passed
        in_valid = (stall > 0);
        payload  = rnd184();
        timestamp = $urandom;
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            errors++; $display("FAIL tag_busy: busy=%b in_ready=%b want 1/0", busy, in_ready);
        end
        n = 0;
        while (frame_valid !== 1'b1 && n < 40) begin
            @(negedge clk); n++;
            if (stall > 0) payload = rnd184();
        end
        checks++;
        if (n != 27) begin
            errors++; $display("FAIL latency: frame_valid after %0d edges want 27", n);
        end
        exp = q0.pop_front();
        frame_ready = 1'b0;
        for (int k = 0; k < stall; k++) begin
            @(negedge clk);
            payload = rnd184();
            checks++;
            if (frame !== exp || in_ready !== 1'b0 || frame_valid !== 1'b1) begin
                errors++;
                $display("FAIL stall_hold: cyc=%0d vld=%b rdy=%b frame=%h want %h", k, frame_valid, in_ready, frame, exp);
            end
        end
        checks++;
        if (frame !== exp) begin
            errors++; $display("FAIL frame: got %h want %h", frame, exp);
        end
        frame_ready = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);                               // handoff edge has passed
        frame_ready = 1'b0;
        exp_cnt0 = exp_cnt0 + 16'd1;
        checks++;
        if (frame_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL handoff_state: vld=%b rdy=%b busy=%b want 0/1/0", frame_valid, in_ready, busy);
        end
        checks++;
        if (frame_count !== exp_cnt0) begin
            errors++; $display("FAIL count: got %h want %h", frame_count, exp_cnt0);
        end
        checks++;
        if (frame !== exp) begin
            errors++; $display("FAIL frame_keep: got %h want %h", frame, exp);
        end
    endtask

    // ---------------- secondary DUT frame driver ----------------
    task automatic d1_do_frame();
        logic [255:0] exp;
        int n;
        d1_timestamp = 32'h0; d1_payload = '0; d1_in_valid = 1'b1;
        q1.push_back({216'h0, ref_tag(40'h1, 216'h0)});
        @(negedge clk);
        d1_in_valid = 1'b0;
        n = 0;
        while (d1_frame_valid !== 1'b1 && n < 40) begin
            @(negedge clk); n++;
        end
        checks++;
        if (n != 27) begin
            errors++; $display("FAIL d1_latency: %0d edges want 27", n);
        end
        exp = q1.pop_front();
        checks++;
        if (d1_frame !== exp) begin
            errors++; $display("FAIL d1_frame: got %h want %h", d1_frame, exp);
        end
        d1_frame_ready = 1'b1;
        @(negedge clk);
        d1_frame_ready = 1'b0;
        exp_cnt1 = exp_cnt1 + 3'd1;
        checks++;
        if (d1_frame_count !== exp_cnt1) begin
            errors++; $display("FAIL d1_count: got %h want %h", d1_frame_count, exp_cnt1);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || frame_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL reset_ctl: rdy=%b vld=%b busy=%b want 1/0/0", in_ready, frame_valid, busy);
        end
        checks++;
        if (frame !== 256'h0 || frame_count !== 16'h0) begin
            errors++; $display("FAIL reset_data: frame=%h cnt=%h want 0/0", frame, frame_count);
        end
        rst_n = 1'b1;
        exp_cnt0 = '0; exp_cnt1 = '0;
        @(negedge clk);
    endtask

    task automatic test_zero();
        do_frame(32'h0, 184'h0, 0);
        checks++;
        if (frame !== 256'h0 || frame_count !== 16'd1) begin
            errors++; $display("FAIL zero_frame: frame=%h cnt=%h want 0/1", frame, frame_count);
        end
    endtask

    task automatic test_pattern();
        do_frame(32'hDEAD_BEEF, 184'h1, 0);
        checks++;
        if (frame[255:224] !== 32'hDEADBEEF || frame[223:40] !== 184'h1) begin
            errors++; $display("FAIL pattern_fields: ts=%h pl=%h want deadbeef/1", frame[255:224], frame[223:40]);
        end
        // With only b_26 non-zero, the tag is that byte alone.
        do_frame(32'h0, 184'h1, 0);
        checks++;
        if (frame[39:0] !== 40'h01) begin
            errors++; $display("FAIL b26_tag: got %h want 0000000001", frame[39:0]);
        end
    endtask

    task automatic test_stall();
        do_frame(32'h1234_5678, rnd184(), 10);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) do_frame($urandom, rnd184(), 0);
    endtask

    task automatic test_reset_mid_tag();
        timestamp = 32'hCAFE_F00D; payload = rnd184(); in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (13) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL midtag_busy: busy=%b want 1", busy);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || frame_valid !== 1'b0 || busy !== 1'b0 ||
            frame !== 256'h0 || frame_count !== 16'h0) begin
            errors++;
            $display("FAIL midtag_reset: rdy=%b vld=%b busy=%b cnt=%h frame=%h", in_ready, frame_valid, busy, frame_count, frame);
        end
        exp_cnt0 = '0; exp_cnt1 = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_frame(32'h0BAD_CAFE, rnd184(), 0);
    endtask

    task automatic test_key();
        d1_do_frame();
        checks++;
        if (d1_frame[39:0] !== 40'h0008000000 || d1_frame[255:40] !== 216'h0) begin
            errors++; $display("FAIL key_tag: got %h want 0008000000 with zero header", d1_frame[39:0]);
        end
    endtask

    task automatic test_wrap();
        while (exp_cnt1 != 3'h7) d1_do_frame();
        checks++;
        if (d1_frame_count !== 3'h7) begin
            errors++; $display("FAIL wrap_full: got %h want 7", d1_frame_count);
        end
        d1_do_frame();
        checks++;
        if (d1_frame_count !== 3'h0) begin
            errors++; $display("FAIL wrap_zero: got %h want 0", d1_frame_count);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; frame_ready = 1'b0; payload = '0; timestamp = '0;
        d1_in_valid = 1'b0; d1_frame_ready = 1'b0; d1_payload = '0; d1_timestamp = '0;
        exp_cnt0 = '0; exp_cnt1 = '0;
        test_reset();
        test_zero();
        test_pattern();
        test_stall();
        test_back_to_back();
        test_reset_mid_tag();
        test_key();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
